// File: rtl/ss_pkg.sv
// Shared types, constants and the BCD increment helper for the stopwatch.
package ss_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2
    } ss_state_e;

    // Raw buttons pull low when pressed.
    localparam logic BTN_ACTIVE = 1'b0;

    localparam int unsigned BCD_W = 4;
    localparam int unsigned SS_W  = 2 * BCD_W;

    typedef struct packed {
        logic            carry;
        logic [SS_W-1:0] value;
    } bcd_inc_t;

    // Two-digit BCD increment; carry set when 99 rolls over to 00.
    function automatic bcd_inc_t bcd_inc(input logic [SS_W-1:0] v);
        bcd_inc_t         r;
        logic [BCD_W-1:0] ones;
        logic [BCD_W-1:0] tens;
        ones    = v[BCD_W-1:0];
        tens    = v[SS_W-1:BCD_W];
        r.carry = 1'b0;
        if (ones >= BCD_W'(9)) begin
            ones = '0;
            if (tens >= BCD_W'(9)) begin
                tens    = '0;
                r.carry = 1'b1;
            end else begin
                tens = tens + BCD_W'(1);
            end
        end else begin
            ones = ones + BCD_W'(1);
        end
        r.value = {tens, ones};
        return r;
    endfunction

endpackage

// File: rtl/ss_debounce.sv
// Button conditioner: 2-flop synchronizer, debounce counter, press pulse.
module ss_debounce
    import ss_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 120000
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic btn_n_i,
    output logic press_o
);

    localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

    logic             sync1_q;
    logic             sync2_q;
    logic             level_q;
    logic             level_d;
    logic             level_prev_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             press_q;
    logic             press_d;

    // Count consecutive samples that disagree with the accepted level.
    always_comb begin
        cnt_d   = cnt_q;
        level_d = level_q;
        if (sync2_q == level_q) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
            level_d = sync2_q;
            cnt_d   = '0;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
        press_d = (level_prev_q != BTN_ACTIVE) && (level_q == BTN_ACTIVE);
    end

    // Synchronizer, debounce state and registered press edge.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync1_q      <= 1'b1;
            sync2_q      <= 1'b1;
            level_q      <= 1'b1;
            level_prev_q <= 1'b1;
            cnt_q        <= '0;
            press_q      <= 1'b0;
        end else begin
            sync1_q      <= btn_n_i;
            sync2_q      <= sync1_q;
            level_q      <= level_d;
            level_prev_q <= level_q;
            cnt_q        <= cnt_d;
            press_q      <= press_d;
        end
    end

    assign press_o = press_q;

endmodule

// File: rtl/ss_stopwatch_ctrl.sv
// Start/pause/clear stopwatch producing a two-digit BCD display value.
module ss_stopwatch_ctrl
    import ss_pkg::*;
#(
    parameter int unsigned     CLK_HZ          = 12000000,
    parameter int unsigned     TICK_HZ         = 1,
    parameter int unsigned     DEBOUNCE_CYCLES = 120000,
    parameter logic [SS_W-1:0] WRAP_BCD        = 8'h99
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic            BTN_START_n,
    input  logic            BTN_CLEAR_n,
    output logic [SS_W-1:0] SS_value,
    output logic            running,
    output logic            tick,
    output logic            wrap
);

    localparam int unsigned DIV  = CLK_HZ / TICK_HZ;
    localparam int unsigned PS_W = (DIV > 1) ? $clog2(DIV) : 1;

    logic            start_press;
    logic            clear_press;

    ss_state_e       state_q;
    ss_state_e       state_d;
    logic [PS_W-1:0] ps_q;
    logic [PS_W-1:0] ps_d;
    logic [SS_W-1:0] value_q;
    logic [SS_W-1:0] value_d;
    logic            tick_q;
    logic            tick_d;
    logic            wrap_q;
    logic            wrap_d;
    logic            running_q;
    bcd_inc_t        inc;

    ss_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_db_start (
        .clk_i   (CLK),
        .rst_i   (RST),
        .btn_n_i (BTN_START_n),
        .press_o (start_press)
    );

    ss_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_db_clear (
        .clk_i   (CLK),
        .rst_i   (RST),
        .btn_n_i (BTN_CLEAR_n),
        .press_o (clear_press)
    );

    // Next state: clear dominates; counting happens before a start/pause transition.
    always_comb begin
        state_d = state_q;
        ps_d    = ps_q;
        value_d = value_q;
        tick_d  = 1'b0;
        wrap_d  = 1'b0;
        inc     = bcd_inc(value_q);

        if (clear_press) begin
            state_d = IDLE;
            ps_d    = '0;
            value_d = '0;
        end else begin
            if (state_q == RUN) begin
                if (ps_q == PS_W'(DIV - 1)) begin
                    ps_d   = '0;
                    tick_d = 1'b1;
                    if ((value_q == WRAP_BCD) || inc.carry) begin
                        value_d = '0;
                        wrap_d  = 1'b1;
                    end else begin
                        value_d = inc.value;
                    end
                end else begin
                    ps_d = ps_q + PS_W'(1);
                end
            end

            case (state_q)
                IDLE: begin
                    if (start_press) begin
                        state_d = RUN;
                        ps_d    = '0;
                    end
                end
                RUN: begin
                    if (start_press) begin
                        state_d = PAUSE;
                    end
                end
                PAUSE: begin
                    if (start_press) begin
                        state_d = RUN;
                    end
                end
                default: begin
                    state_d = IDLE;
                    ps_d    = '0;
                    value_d = '0;
                end
            endcase
        end
    end

    // State, prescaler and registered outputs.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q   <= IDLE;
            ps_q      <= '0;
            value_q   <= '0;
            tick_q    <= 1'b0;
            wrap_q    <= 1'b0;
            running_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ps_q      <= ps_d;
            value_q   <= value_d;
            tick_q    <= tick_d;
            wrap_q    <= wrap_d;
            running_q <= (state_d == RUN);
        end
    end

    assign SS_value = value_q;
    assign running  = running_q;
    assign tick     = tick_q;
    assign wrap     = wrap_q;

endmodule

// File: tb/tb_ss_stopwatch_ctrl.sv
// Directed bench for the stopwatch: 10 cycles per tick, 4-cycle debounce.
module tb_ss_stopwatch_ctrl;

    logic       CLK;
    logic       RST;
    logic       BTN_START_n;
    logic       BTN_CLEAR_n;
    logic [7:0] SS_value;
    logic       running;
    logic       tick;
    logic       wrap;

    int checks;
    int errors;
    int cur;

    ss_stopwatch_ctrl #(
        .CLK_HZ          (100),
        .TICK_HZ         (10),
        .DEBOUNCE_CYCLES (4),
        .WRAP_BCD        (8'h99)
    ) dut (
        .CLK         (CLK),
        .RST         (RST),
        .BTN_START_n (BTN_START_n),
        .BTN_CLEAR_n (BTN_CLEAR_n),
        .SS_value    (SS_value),
        .running     (running),
        .tick        (tick),
        .wrap        (wrap)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    function automatic logic [7:0] to_bcd(input int n);
        int m;
        m = n % 100;
        return {4'(m / 10), 4'(m % 10)};
    endfunction

    task automatic cyc();
        @(negedge CLK);
    endtask

    task automatic wait_tick(input int budget, output int waited, output bit ok);
        waited = 0;
        do begin
            cyc();
            waited++;
        end while (tick !== 1'b1 && waited < budget);
        ok = (tick === 1'b1);
    endtask

    task automatic test_reset();
        int bad;
        RST = 1'b1;
        BTN_START_n = 1'b1;
        BTN_CLEAR_n = 1'b1;
        repeat (3) cyc();
        checks++; if (SS_value !== 8'h00) begin errors++; $display("FAIL reset_value got %h want 00", SS_value); end
        checks++; if (running !== 1'b0) begin errors++; $display("FAIL reset_running got %b want 0", running); end
        checks++; if (tick !== 1'b0) begin errors++; $display("FAIL reset_tick got %b want 0", tick); end
        checks++; if (wrap !== 1'b0) begin errors++; $display("FAIL reset_wrap got %b want 0", wrap); end
        RST = 1'b0;
        bad = 0;
        repeat (50) begin
            cyc();
            if (SS_value !== 8'h00 || running !== 1'b0 || tick !== 1'b0 || wrap !== 1'b0) bad++;
        end
        checks++; if (bad != 0) begin errors++; $display("FAIL idle_quiet bad cycles %0d want 0", bad); end
    endtask

    task automatic test_count_and_wrap();
        int  early;
        int  w;
        bit  ok;
        logic wexp;
        cur = 0;
        BTN_START_n = 1'b0;
        for (int n = 1; n <= 8; n++) begin
            cyc();
            if (n == 7) begin
                checks++; if (running !== 1'b0) begin errors++; $display("FAIL start_latency_early running %b want 0", running); end
            end
            if (n == 8) begin
                checks++; if (running !== 1'b1) begin errors++; $display("FAIL start_latency running %b want 1", running); end
            end
        end
        BTN_START_n = 1'b1;
        early = 0;
        for (int n = 1; n <= 10; n++) begin
            cyc();
            if (n < 10 && tick !== 1'b0) early++;
        end
        checks++; if (early != 0) begin errors++; $display("FAIL first_tick_early count %0d want 0", early); end
        checks++; if (tick !== 1'b1) begin errors++; $display("FAIL first_tick got %b want 1", tick); end
        checks++; if (SS_value !== 8'h01) begin errors++; $display("FAIL first_value got %h want 01", SS_value); end
        cur = 1;
        for (int n = 2; n <= 100; n++) begin
            wait_tick(20, w, ok);
            checks++; if (!ok) begin errors++; $display("FAIL tick_timeout n=%0d waited %0d", n, w); end
            checks++; if (w != 10) begin errors++; $display("FAIL tick_period n=%0d got %0d want 10", n, w); end
            cur = n % 100;
            checks++; if (SS_value !== to_bcd(n)) begin errors++; $display("FAIL count_value n=%0d got %h want %h", n, SS_value, to_bcd(n)); end
            wexp = (n == 100);
            checks++; if (wrap !== wexp) begin errors++; $display("FAIL wrap_flag n=%0d got %b want %b", n, wrap, wexp); end
        end
        cyc();
        checks++; if (tick !== 1'b0 || wrap !== 1'b0) begin errors++; $display("FAIL wrap_pulse_width tick %b wrap %b want 0 0", tick, wrap); end
        checks++; if (running !== 1'b1 || SS_value !== 8'h00) begin errors++; $display("FAIL after_wrap running %b value %h want 1 00", running, SS_value); end
    endtask

    task automatic test_glitch();
        int bad;
        int ticks;
        bad = 0;
        ticks = 0;
        for (int g = 0; g < 5; g++) begin
            BTN_START_n = 1'b0;
            repeat (3) begin
                cyc();
                if (running !== 1'b1) bad++;
                if (tick === 1'b1) ticks++;
            end
            BTN_START_n = 1'b1;
            repeat (3) begin
                cyc();
                if (running !== 1'b1) bad++;
                if (tick === 1'b1) ticks++;
            end
        end
        checks++; if (bad != 0) begin errors++; $display("FAIL glitch_running bad cycles %0d want 0", bad); end
        checks++; if (ticks != 3) begin errors++; $display("FAIL glitch_ticks got %0d want 3", ticks); end
        cur = 3;
        checks++; if (SS_value !== to_bcd(cur)) begin errors++; $display("FAIL glitch_value got %h want %h", SS_value, to_bcd(cur)); end
    endtask

    task automatic test_pause_resume();
        int w;
        bit ok;
        int ticks;
        int bad;
        wait_tick(20, w, ok);
        cur = 4;
        checks++; if (!ok || SS_value !== to_bcd(cur)) begin errors++; $display("FAIL pre_pause_tick ok %b value %h want %h", ok, SS_value, to_bcd(cur)); end
        repeat (8) cyc();
        BTN_START_n = 1'b0;
        ticks = 0;
        for (int n = 1; n <= 8; n++) begin
            cyc();
            if (tick === 1'b1) ticks++;
            if (n == 7) begin
                checks++; if (running !== 1'b1) begin errors++; $display("FAIL pause_early running %b want 1", running); end
            end
            if (n == 8) begin
                checks++; if (running !== 1'b0) begin errors++; $display("FAIL pause_enter running %b want 0", running); end
            end
        end
        BTN_START_n = 1'b1;
        cur = 5;
        checks++; if (ticks != 1) begin errors++; $display("FAIL pause_hold_ticks got %0d want 1", ticks); end
        checks++; if (SS_value !== to_bcd(cur)) begin errors++; $display("FAIL pause_value got %h want %h", SS_value, to_bcd(cur)); end
        bad = 0;
        repeat (30) begin
            cyc();
            if (running !== 1'b0 || tick !== 1'b0 || SS_value !== to_bcd(cur)) bad++;
        end
        checks++; if (bad != 0) begin errors++; $display("FAIL pause_frozen bad cycles %0d want 0", bad); end
        BTN_START_n = 1'b0;
        for (int n = 1; n <= 8; n++) begin
            cyc();
            if (n == 7) begin
                checks++; if (running !== 1'b0) begin errors++; $display("FAIL resume_early running %b want 0", running); end
            end
            if (n == 8) begin
                checks++; if (running !== 1'b1) begin errors++; $display("FAIL resume running %b want 1", running); end
            end
        end
        BTN_START_n = 1'b1;
        bad = 0;
        for (int n = 1; n <= 4; n++) begin
            cyc();
            if (n < 4 && tick !== 1'b0) bad++;
        end
        cur = 6;
        checks++; if (bad != 0) begin errors++; $display("FAIL resume_tick_early count %0d want 0", bad); end
        checks++; if (tick !== 1'b1) begin errors++; $display("FAIL resume_tick got %b want 1", tick); end
        checks++; if (SS_value !== to_bcd(cur)) begin errors++; $display("FAIL resume_value got %h want %h", SS_value, to_bcd(cur)); end
    endtask

    task automatic test_clear_wins();
        int w;
        bit ok;
        int bad;
        while (cur < 37) begin
            wait_tick(20, w, ok);
            checks++; if (!ok) begin errors++; $display("FAIL run_to_37_timeout at %0d waited %0d", cur, w); end
            cur++;
        end
        checks++; if (SS_value !== 8'h37) begin errors++; $display("FAIL value_37 got %h want 37", SS_value); end
        BTN_START_n = 1'b0;
        BTN_CLEAR_n = 1'b0;
        bad = 0;
        for (int n = 1; n <= 8; n++) begin
            cyc();
            if (tick !== 1'b0) bad++;
            if (n == 7) begin
                checks++; if (running !== 1'b1 || SS_value !== 8'h37) begin errors++; $display("FAIL clear_early running %b value %h want 1 37", running, SS_value); end
            end
            if (n == 8) begin
                checks++; if (running !== 1'b0) begin errors++; $display("FAIL clear_running got %b want 0", running); end
                checks++; if (SS_value !== 8'h00) begin errors++; $display("FAIL clear_value got %h want 00", SS_value); end
            end
        end
        BTN_START_n = 1'b1;
        BTN_CLEAR_n = 1'b1;
        checks++; if (bad != 0) begin errors++; $display("FAIL clear_no_tick count %0d want 0", bad); end
        bad = 0;
        repeat (20) begin
            cyc();
            if (running !== 1'b0 || tick !== 1'b0 || SS_value !== 8'h00) bad++;
        end
        checks++; if (bad != 0) begin errors++; $display("FAIL clear_idle bad cycles %0d want 0", bad); end
        cur = 0;
    endtask

    task automatic test_reset_mid();
        int w;
        bit ok;
        int bad;
        BTN_START_n = 1'b0;
        for (int n = 1; n <= 8; n++) begin
            cyc();
            if (n == 8) begin
                checks++; if (running !== 1'b1) begin errors++; $display("FAIL restart running %b want 1", running); end
            end
        end
        BTN_START_n = 1'b1;
        cur = 0;
        while (cur < 42) begin
            wait_tick(20, w, ok);
            checks++; if (!ok) begin errors++; $display("FAIL run_to_42_timeout at %0d waited %0d", cur, w); end
            cur++;
        end
        checks++; if (SS_value !== 8'h42) begin errors++; $display("FAIL value_42 got %h want 42", SS_value); end
        BTN_CLEAR_n = 1'b0;
        repeat (3) cyc();
        RST = 1'b1;
        cyc();
        checks++; if (SS_value !== 8'h00) begin errors++; $display("FAIL rst_mid_value got %h want 00", SS_value); end
        checks++; if (running !== 1'b0 || tick !== 1'b0 || wrap !== 1'b0) begin errors++; $display("FAIL rst_mid_flags running %b tick %b wrap %b want 0 0 0", running, tick, wrap); end
        RST = 1'b0;
        BTN_CLEAR_n = 1'b1;
        bad = 0;
        repeat (30) begin
            cyc();
            if (running !== 1'b0 || tick !== 1'b0 || SS_value !== 8'h00) bad++;
        end
        checks++; if (bad != 0) begin errors++; $display("FAIL rst_idle bad cycles %0d want 0", bad); end
        BTN_START_n = 1'b0;
        for (int n = 1; n <= 8; n++) begin
            cyc();
            if (n == 7) begin
                checks++; if (running !== 1'b0) begin errors++; $display("FAIL post_rst_early running %b want 0", running); end
            end
            if (n == 8) begin
                checks++; if (running !== 1'b1) begin errors++; $display("FAIL post_rst_start running %b want 1", running); end
            end
        end
        BTN_START_n = 1'b1;
        bad = 0;
        for (int n = 1; n <= 10; n++) begin
            cyc();
            if (n < 10 && tick !== 1'b0) bad++;
        end
        checks++; if (bad != 0) begin errors++; $display("FAIL post_rst_tick_early count %0d want 0", bad); end
        checks++; if (tick !== 1'b1 || SS_value !== 8'h01) begin errors++; $display("FAIL post_rst_first_tick tick %b value %h want 1 01", tick, SS_value); end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        cur = 0;
        RST = 1'b1;
        BTN_START_n = 1'b1;
        BTN_CLEAR_n = 1'b1;
        test_reset();
        test_count_and_wrap();
        test_glitch();
        test_pause_resume();
        test_clear_wins();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
